// File: rtl/stac_multi_tdr.sv
// Serial test access controller: 16-state TAP, IR_W-bit IR, N_TDR selectable TDRs plus bypass.
// WSO is combinational from the shift stage; updates land one TCLK after UpdDR/UpdIR; no backpressure.
module stac_multi_tdr #(
  parameter int                IR_W    = 8,
  parameter int                TDR_W   = 33,
  parameter int                N_TDR   = 4,
  parameter logic [N_TDR-1:0]  RO_MASK = N_TDR'(4'b1000)
) (
  input  logic                     TCLK,
  input  logic                     TRESETN,
  input  logic                     TMS,
  input  logic                     WSI,
  output logic                     WSO,
  input  logic [N_TDR*TDR_W-1:0]   tdr_pi,
  output logic [N_TDR*TDR_W-1:0]   tdr_po,
  output logic [N_TDR-1:0]         upd_stb,
  output logic [IR_W-1:0]          ir_out,
  output logic [3:0]               tap_state
);

  localparam logic [3:0] S_TLR   = 4'hF;
  localparam logic [3:0] S_RTI   = 4'hC;
  localparam logic [3:0] S_SELDR = 4'h7;
  localparam logic [3:0] S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR  = 4'h2;
  localparam logic [3:0] S_EX1DR = 4'h1;
  localparam logic [3:0] S_PAUDR = 4'h3;
  localparam logic [3:0] S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5;
  localparam logic [3:0] S_SELIR = 4'h4;
  localparam logic [3:0] S_CAPIR = 4'hE;
  localparam logic [3:0] S_SHIR  = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9;
  localparam logic [3:0] S_PAUIR = 4'hB;
  localparam logic [3:0] S_EX2IR = 4'h8;
  localparam logic [3:0] S_UPDIR = 4'hD;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [IR_W-1:0]  r_ir_sr;
  logic [IR_W-1:0]  r_ir;
  logic             r_byp;
  logic [N_TDR-1:0] w_sel;
  logic [N_TDR-1:0] w_so;
  logic             w_byp_sel;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:   w_next = TMS ? S_TLR   : S_RTI;
      S_RTI:   w_next = TMS ? S_SELDR : S_RTI;
      S_SELDR: w_next = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = TMS ? S_UPDDR : S_PAUDR;
      S_PAUDR: w_next = TMS ? S_EX2DR : S_PAUDR;
      S_EX2DR: w_next = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = TMS ? S_SELDR : S_RTI;
      S_SELIR: w_next = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = TMS ? S_UPDIR : S_PAUIR;
      S_PAUIR: w_next = TMS ? S_EX2IR : S_PAUIR;
      S_EX2IR: w_next = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = TMS ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
  end

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) r_state <= S_TLR;
    else          r_state <= w_next;
  end

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      r_ir_sr <= '0;
      r_ir    <= '1;
    end else begin
      case (r_state)
        S_CAPIR: r_ir_sr <= IR_W'(1);
        S_SHIR:  r_ir_sr <= {WSI, r_ir_sr[IR_W-1:1]};
        S_UPDIR: r_ir    <= r_ir_sr;
        S_TLR:   r_ir    <= '1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN)                r_byp <= 1'b0;
    else if (r_state == S_CAPDR) r_byp <= 1'b0;
    else if (r_state == S_SHDR)  r_byp <= WSI;
  end

  // Codes 1..N_TDR pick a channel; every other code (0, all-ones, out of range) is bypass.
  assign w_byp_sel = ~|w_sel;

  for (genvar k = 0; k < N_TDR; k++) begin : g_tdr
    logic [TDR_W-1:0] r_sr;
    logic [TDR_W-1:0] r_po;
    logic             r_stb;
    logic [TDR_W-1:0] w_cap;

    assign w_sel[k] = (r_ir == IR_W'(k + 1));
    // Read/write channels read back their own update register; read-only ones sample tdr_pi.
    assign w_cap    = RO_MASK[k] ? tdr_pi[k*TDR_W +: TDR_W] : r_po;

    always_ff @(posedge TCLK or negedge TRESETN) begin
      if (!TRESETN) begin
        r_sr  <= '0;
        r_po  <= '0;
        r_stb <= 1'b0;
      end else begin
        r_stb <= 1'b0;
        if (w_sel[k]) begin
          case (r_state)
            S_CAPDR: r_sr <= w_cap;
            S_SHDR:  r_sr <= {WSI, r_sr[TDR_W-1:1]};
            S_UPDDR: begin
              if (!RO_MASK[k]) begin
                r_po  <= r_sr;
                r_stb <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign w_so[k]                    = r_sr[0];
    assign tdr_po[k*TDR_W +: TDR_W]   = r_po;
    assign upd_stb[k]                 = r_stb;
  end

  always_comb begin
    WSO = 1'b0;
    case (r_state)
      S_SHIR:  WSO = r_ir_sr[0];
      S_SHDR:  WSO = w_byp_sel ? r_byp : |(w_sel & w_so);
      default: ;
    endcase
  end

  assign ir_out    = r_ir;
  assign tap_state = r_state;

endmodule
